// File: rtl/sseg_rx.sv
// Seven-segment display bus receiver: recovers digit values and complete
// four-digit frames from a multiplexed, active-low segment/anode bus.
module sseg_rx #(
    parameter int STABLE = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  hex,
    input  logic [3:0]  an,
    output logic [3:0]  num,
    output logic        dp,
    output logic        sign,
    output logic        err,
    output logic [1:0]  digit,
    output logic        valid,
    output logic [15:0] frame,
    output logic        frame_err,
    output logic        frame_valid
);

    localparam logic [7:0] STABLE_C = 8'(STABLE);

    logic [7:0]  hex_p0, hex_p1;
    logic [3:0]  an_p0, an_p1;
    logic [7:0]  cnt;
    logic [3:0]  mask;
    logic [15:0] slot_num;
    logic [3:0]  slot_err;

    logic        clear_cnt;
    logic        hit;
    logic [5:0]  dec;
    logic [1:0]  idx;
    logic [3:0]  sel_bit;
    logic [3:0]  base;
    logic [15:0] frame_next;
    logic [3:0]  ferr_vec;

    function automatic logic onehot_low(input logic [3:0] a);
        return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
    endfunction

    // Result packing is {err, sign, num}.
    function automatic logic [5:0] decode(input logic [6:0] seg);
        case (seg)
            7'h40:   decode = 6'h00;
            7'h79:   decode = 6'h01;
            7'h24:   decode = 6'h02;
            7'h30:   decode = 6'h03;
            7'h19:   decode = 6'h04;
            7'h12:   decode = 6'h05;
            7'h02:   decode = 6'h06;
            7'h78:   decode = 6'h07;
            7'h00:   decode = 6'h08;
            7'h10:   decode = 6'h09;
            7'h08:   decode = 6'h0A;
            7'h03:   decode = 6'h0B;
            7'h27:   decode = 6'h0C;
            7'h21:   decode = 6'h0D;
            7'h06:   decode = 6'h0E;
            7'h0E:   decode = 6'h0F;
            7'h3F:   decode = 6'b010000;
            default: decode = 6'b100000;
        endcase
    endfunction

    function automatic logic [1:0] sel_index(input logic [3:0] a);
        case (a)
            4'b1101: sel_index = 2'd1;
            4'b1011: sel_index = 2'd2;
            4'b0111: sel_index = 2'd3;
            default: sel_index = 2'd0;
        endcase
    endfunction

    // Stage p0 holds the value the synchronized bus takes next cycle, so
    // the counter reflects the stability of the value it is updated into.
    assign clear_cnt = ({an_p0, hex_p0} != {an_p1, hex_p1}) || !onehot_low(an_p0);
    assign hit       = !clear_cnt && (cnt == STABLE_C - 8'd1);
    assign dec       = decode(hex_p1[6:0]);
    assign idx       = sel_index(an_p1);
    assign sel_bit   = 4'b0001 << idx;
    assign base      = {idx, 2'b00};

    // Frame assembly includes the capture happening in this same cycle.
    always_comb begin
        frame_next = slot_num;
        ferr_vec   = slot_err;
        frame_next[base +: 4] = dec[3:0];
        ferr_vec[idx]         = dec[5] | dec[4];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hex_p0      <= 8'hFF;
            hex_p1      <= 8'hFF;
            an_p0       <= 4'hF;
            an_p1       <= 4'hF;
            cnt         <= 8'd0;
            valid       <= 1'b0;
            num         <= 4'd0;
            dp          <= 1'b0;
            sign        <= 1'b0;
            err         <= 1'b0;
            digit       <= 2'd0;
            mask        <= 4'd0;
            slot_num    <= 16'd0;
            slot_err    <= 4'd0;
            frame       <= 16'd0;
            frame_err   <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            // Synchronizer stages p0 -> p1
            hex_p0 <= hex;
            hex_p1 <= hex_p0;
            an_p0  <= an;
            an_p1  <= an_p0;

            if (clear_cnt)
                cnt <= 8'd0;
            else if (cnt != STABLE_C)
                cnt <= cnt + 8'd1;

            valid       <= hit;
            frame_valid <= 1'b0;

            // Capture stage: digit outputs and frame slots
            if (hit) begin
                num   <= dec[3:0];
                sign  <= dec[4];
                err   <= dec[5];
                dp    <= ~hex_p1[7];
                digit <= idx;
                slot_num[base +: 4] <= dec[3:0];
                slot_err[idx]       <= dec[5] | dec[4];
                if ((mask | sel_bit) == 4'hF) begin
                    frame_valid <= 1'b1;
                    frame       <= frame_next;
                    frame_err   <= |ferr_vec;
                    mask        <= 4'd0;
                end else begin
                    mask <= mask | sel_bit;
                end
            end
        end
    end

endmodule

// File: tb/tb_sseg_rx.sv
// Self-checking bench for sseg_rx: directed scenarios plus random bus traffic
// compared cycle by cycle against a run-length reference model.
module tb_sseg_rx;

    localparam int STABLE = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  hex;
    logic [3:0]  an;
    logic [3:0]  num;
    logic        dp, sign, err, valid, frame_err, frame_valid;
    logic [1:0]  digit;
    logic [15:0] frame;

    sseg_rx #(.STABLE(STABLE)) dut (
        .clk(clk), .reset(reset), .hex(hex), .an(an),
        .num(num), .dp(dp), .sign(sign), .err(err), .digit(digit),
        .valid(valid), .frame(frame), .frame_err(frame_err),
        .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    logic [11:0] last_p, prev_s;
    logic        last_r;
    int          run;
    logic [3:0]  e_num;
    logic        e_dp, e_sign, e_err, e_valid, e_fv, e_ferr;
    logic [1:0]  e_digit;
    logic [15:0] e_frame;
    logic [3:0]  e_seen;
    logic [3:0]  e_snum [4];
    logic        e_serr [4];

    int cyc, vcnt, fvcnt, vpos, t0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        run = 0;
        e_num = 0; e_dp = 0; e_sign = 0; e_err = 0; e_digit = 0;
        e_valid = 0; e_fv = 0; e_frame = 0; e_ferr = 0; e_seen = 0;
        for (int i = 0; i < 4; i++) begin
            e_snum[i] = 0;
            e_serr[i] = 0;
        end
    endtask

    task automatic tick();
        logic [11:0] cur_p, s;
        logic        cur_r;
        int          d;
        cur_p = {an, hex};
        cur_r = reset;
        @(posedge clk);
        #1;
        cyc++;
        // The bus seen by the logic is the pin value from two edges back,
        // or idle if reset was sampled on either of those edges.
        s = (cur_r || last_r) ? 12'hFFF : last_p;
        last_p = cur_p;
        last_r = cur_r;
        if (cur_r) begin
            model_clear();
        end else begin
            run = (s == prev_s) ? run + 1 : 1;
            e_fv = 0;
            e_valid = ($countones(~s[11:8]) == 1) && (run == STABLE + 1);
            if (e_valid) begin
                d = 0;
                for (int i = 0; i < 4; i++) if (!s[8+i]) d = i;
                e_num = 0; e_sign = 0; e_err = 1;
                for (int i = 0; i < 16; i++)
                    if (s[6:0] == pat[i]) begin e_num = 4'(i); e_err = 0; end
                if (s[6:0] == 7'h3F) begin e_sign = 1; e_err = 0; end
                e_dp = !s[7];
                e_digit = 2'(d);
                e_snum[d] = e_num;
                e_serr[d] = e_err | e_sign;
                e_seen[d] = 1'b1;
                if (e_seen == 4'hF) begin
                    e_fv = 1;
                    e_frame = {e_snum[3], e_snum[2], e_snum[1], e_snum[0]};
                    e_ferr = e_serr[0] | e_serr[1] | e_serr[2] | e_serr[3];
                    e_seen = 0;
                end
            end
        end
        prev_s = s;
        if (valid === 1'b1) begin vcnt++; vpos = cyc; end
        if (frame_valid === 1'b1) fvcnt++;
        chk("valid", valid, e_valid);
        chk("frame_valid", frame_valid, e_fv);
        chk("num", num, e_num);
        chk("dp", dp, e_dp);
        chk("sign", sign, e_sign);
        chk("err", err, e_err);
        chk("digit", digit, e_digit);
        chk("frame", frame, e_frame);
        chk("frame_err", frame_err, e_ferr);
    endtask

    task automatic hold(input logic [3:0] a, input logic [7:0] h, input int n);
        an = a;
        hex = h;
        repeat (n) tick();
    endtask

    initial begin
        logic [3:0] ra;
        logic [7:0] rh;
        reset = 1'b1; an = 4'hF; hex = 8'hFF;
        last_p = 12'hFFF; prev_s = 12'hFFF; last_r = 1'b1;
        cyc = 0; vcnt = 0; fvcnt = 0; vpos = 0;
        model_clear();
        repeat (3) tick();
        chk("reset_frame", frame, 16'h0000);
        chk("reset_valid", valid, 1'b0);
        reset = 1'b0;

        // Single held digit: one valid, ten cycles after the pins settle
        vcnt = 0; t0 = cyc;
        hold(4'b1110, 8'hA4, 20);
        chk("r030_vcount", vcnt, 1);
        chk("r030_latency", vpos - t0, 10);
        chk("r030_num", num, 4'd2);
        chk("r030_dp", dp, 1'b0);
        chk("r030_digit", digit, 2'd0);
        chk("r030_err", err, 1'b0);

        // Full scan 0..3
        vcnt = 0; fvcnt = 0;
        hold(4'b1110, 8'hC0, 12);
        hold(4'b1101, 8'hF9, 12);
        hold(4'b1011, 8'hA4, 12);
        hold(4'b0111, 8'hB0, 12);
        chk("r031_vcount", vcnt, 4);
        chk("r031_fvcount", fvcnt, 1);
        chk("r031_frame", frame, 16'h3210);
        chk("r031_ferr", frame_err, 1'b0);

        // Minus sign and blank digit
        fvcnt = 0;
        hold(4'b1011, 8'h3F, 12);
        chk("r032_sign", sign, 1'b1);
        chk("r032_digit", digit, 2'd2);
        chk("r032_dp", dp, 1'b1);
        hold(4'b1110, 8'hC0, 12);
        hold(4'b1101, 8'hF9, 12);
        hold(4'b0111, 8'hFF, 12);
        chk("r032_err", err, 1'b1);
        chk("r032_num", num, 4'd0);
        chk("r032_ferr", frame_err, 1'b1);
        chk("r032_fvcount", fvcnt, 1);

        // Two digit selects low, and a bus that never settles long enough
        vcnt = 0;
        hold(4'b1100, 8'hC0, 20);
        repeat (4) begin
            hold(4'b1110, 8'hC0, 5);
            hold(4'b1110, 8'hF9, 5);
        end
        chk("r033_vcount", vcnt, 0);

        // Reset mid-frame and mid-count
        hold(4'b1110, 8'hC0, 12);
        hold(4'b1101, 8'hF9, 12);
        hold(4'b1011, 8'hA4, 12);
        hold(4'b0111, 8'hB0, 4);
        reset = 1'b1;
        hold(4'hF, 8'hFF, 2);
        reset = 1'b0;
        chk("r034_num", num, 4'd0);
        chk("r034_digit", digit, 2'd0);
        chk("r034_frame", frame, 16'h0000);
        fvcnt = 0;
        hold(4'b1110, 8'hF9, 12);
        hold(4'b1101, 8'hA4, 12);
        hold(4'b1011, 8'hB0, 12);
        hold(4'b0111, 8'h99, 12);
        chk("r034_fvcount", fvcnt, 1);
        chk("r034_frame2", frame, 16'h4321);

        // Recapture of digit 1 overwrites its slot
        hold(4'b1110, 8'hC0, 12);
        hold(4'b1101, 8'h92, 12);
        hold(4'b1101, 8'h90, 12);
        hold(4'b1011, 8'hA4, 12);
        hold(4'b0111, 8'hB0, 12);
        chk("r035_nibble", frame[7:4], 4'h9);

        // Random traffic
        repeat (60) begin
            case ($urandom_range(0, 4))
                0:       ra = 4'($urandom_range(0, 15));
                default: ra = ~(4'b0001 << $urandom_range(0, 3));
            endcase
            case ($urandom_range(0, 3))
                0:       rh = {1'($urandom_range(0, 1)), 7'h3F};
                1:       rh = 8'($urandom);
                default: rh = {1'($urandom_range(0, 1)), pat[$urandom_range(0, 15)]};
            endcase
            hold(ra, rh, $urandom_range(1, 14));
        end
        hold(4'hF, 8'hFF, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sseg_rx.md
SSEG_RX -- requirements
Module: sseg_rx

Interface (parameters)
REQ-001 SHALL have parameter STABLE, default 8: consecutive synchronized cycles that a one-hot digit select and segment bus must hold before capture; legal range 2..255.

Interface (ports)
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port hex  input  8  multiplexed display bus; bit7 = ~dp, bits6:0 = active-low segments g..a.
REQ-005 SHALL have port an  input  4  active-low digit selects; bit i low = digit i driven.
REQ-006 SHALL have port num  output  4  decoded value of last captured digit.
REQ-007 SHALL have port dp  output  1  decimal point of last capture, 1 = lit.
REQ-008 SHALL have port sign  output  1  last capture was the minus pattern.
REQ-009 SHALL have port err  output  1  last capture was an unrecognized pattern.
REQ-010 SHALL have port digit  output  2  index of last captured digit.
REQ-011 SHALL have port valid  output  1  one-cycle pulse; num/dp/sign/err/digit updated this cycle.
REQ-012 SHALL have port frame  output  16  {num3,num2,num1,num0} of the completed frame.
REQ-013 SHALL have port frame_err  output  1  OR of err or sign over the four digits of the frame.
REQ-014 SHALL have port frame_valid  output  1  one-cycle pulse; frame/frame_err updated this cycle.

Function
REQ-015 SHALL pass hex and an through a two-flop synchronizer; all logic below uses synchronized values (hs, as).
REQ-016 SHALL decode hs[6:0]: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 27->C, 21->D, 06->E, 0E->F (hex values), producing sign=0, err=0.
REQ-017 SHALL decode hs[6:0]=3F as sign=1, num=0, err=0; every other pattern, including blank 7F, as err=1, num=0, sign=0.
REQ-018 SHALL set dp = ~hs[7] for every capture, independent of the pattern.
REQ-019 SHALL keep a stability counter (8 bits) cleared whenever {as,hs} differs from its previous-cycle value or as is not one-hot; otherwise incremented, saturating at STABLE.
REQ-020 SHALL assert valid for exactly the one cycle in which the counter transitions to STABLE; no further valid until the counter is cleared again.
REQ-021 SHALL produce valid STABLE cycles after the first cycle of a new stable synchronized value, i.e. STABLE+2 cycles after the pins settle.
REQ-022 SHALL never capture while as = 4'hF, or while two or more bits of as are low.
REQ-023 SHALL register num/dp/sign/err/digit on valid and hold them until the next valid.
REQ-024 SHALL keep a 4-bit seen mask and per-digit num/err registers; each capture writes slot digit and sets mask bit digit (recapture of a seen digit overwrites the slot).
REQ-025 SHALL, in the cycle the mask becomes 4'hF, pulse frame_valid, load frame/frame_err from the slots including the capture of that same cycle, and clear the mask.
REQ-026 SHALL hold frame/frame_err between frame_valid pulses.

Reset
REQ-027 SHALL, on reset, clear num, dp, sign, err, digit, valid, frame, frame_err, frame_valid, mask, slots and counter to 0.
REQ-028 SHALL load synchronizer flops with idle values hex=8'hFF, an=4'hF on reset, so no capture occurs within STABLE+2 cycles after release.
REQ-029 SHALL abandon any partial stability count or partial frame when reset is asserted mid-operation.

Verification
REQ-030 SHALL be verified: an=4'b1110, hex=8'hA4 held 20 cycles, STABLE=8 -> single valid at cycle 10 after settling, num=2, dp=0, digit=0, err=0.
REQ-031 SHALL be verified: scan digits 0..3 with 40,79,24,30 (dp bit 1), 12 cycles each -> four valid pulses; frame_valid with the fourth, frame=16'h3210, frame_err=0.
REQ-032 SHALL be verified: an=4'b1011, hex=8'h3F -> sign=1, digit=2; completing the frame gives frame_err=1; hex=8'h7F on another digit -> err=1, num=0.
REQ-033 SHALL be verified: an=4'b1100, or hex toggling every 5 cycles with STABLE=8 -> no valid pulse.
REQ-034 SHALL be verified: reset asserted after three of four digits captured -> all outputs 0; next four digits then produce exactly one frame_valid.
REQ-035 SHALL be verified: digit 1 captured twice (values 5 then 9) before the frame completes -> frame[7:4]=9.
